// File: rtl/tx_uart_pkg.sv
// Shared types and constants for the FIFO-buffered UART transmitter.
package tx_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Frame data-bit count from the 2-bit data_bits code (0 => 5 .. 3 => 8).
    function automatic logic [3:0] frame_nbits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/tx_uart_sync_fifo.sv
// Synchronous FIFO with wrapping pointers and a registered occupancy count.
module tx_uart_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              do_push, do_pop;

    // Full/empty come from the registered level only, so a same-cycle pop never frees a slot.
    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/tx_uart_fifo.sv
// FIFO-buffered UART transmitter with configurable frame format and back-to-back frames.
module tx_uart_fifo
    import tx_uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              div,
    input  logic [1:0]                    data_bits,
    input  logic [1:0]                    parity,
    input  logic                          stop2,
    input  logic                          valid,
    input  logic [DATA_W-1:0]             tx_data,
    output logic                          ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          tx_done
);

    localparam int unsigned IDX_W    = $clog2(DATA_W);
    localparam logic [3:0]  MAX_BITS = 4'(DATA_W);

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    tx_uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (valid),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;
    logic              stop_half_q, stop_half_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        par_q, par_d;
    logic              stop2_q, stop2_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_done_q, tx_done_d;

    logic              sym_last;
    logic              start_frame;
    logic [3:0]        nbits_cfg;
    logic [DATA_W-1:0] data_masked;
    logic              par_bit;

    assign sym_last = (cnt_q == div_q - DIV_W'(1));

    always_comb begin
        nbits_cfg = frame_nbits(data_bits);
        if (nbits_cfg > MAX_BITS) begin
            nbits_cfg = MAX_BITS;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DATA_W); i++) begin
            data_masked[i] = data_q[i] & (IDX_W'(i) <= last_idx_q);
        end
        par_bit = (^data_masked) ^ (par_q == PAR_ODD);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_idx_d  = last_idx_q;
        stop_half_d = stop_half_q;
        data_d      = data_q;
        div_d       = div_q;
        par_d       = par_q;
        stop2_d     = stop2_q;
        tx_out_d    = 1'b1;
        tx_done_d   = 1'b0;
        start_frame = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end
            StStart: begin
                tx_out_d = 1'b0;
                if (sym_last) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                tx_out_d = data_q[idx_q];
                if (sym_last) begin
                    if (idx_q == last_idx_q) begin
                        state_d     = parity_enabled(par_q) ? StParity : StStop;
                        stop_half_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StParity: begin
                tx_out_d = par_bit;
                if (sym_last) begin
                    state_d     = StStop;
                    stop_half_d = 1'b0;
                end
            end
            StStop: begin
                if (sym_last) begin
                    if (!stop2_q || stop_half_q) begin
                        tx_done_d = 1'b1;
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        stop_half_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame setup shared by IDLE and the back-to-back path out of STOP.
        if (start_frame) begin
            fifo_pop   = 1'b1;
            state_d    = StStart;
            data_d     = fifo_rdata;
            div_d      = (div == '0) ? DIV_W'(1) : div;
            par_d      = parity;
            stop2_d    = stop2;
            last_idx_d = IDX_W'(nbits_cfg - 4'd1);
        end

        if (state_q == StIdle || sym_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // tx_out and tx_done are registered, so the line trails the FSM state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            last_idx_q  <= '0;
            stop_half_q <= 1'b0;
            data_q      <= '0;
            div_q       <= DIV_W'(1);
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            tx_out_q    <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            last_idx_q  <= last_idx_d;
            stop_half_q <= stop_half_d;
            data_q      <= data_d;
            div_q       <= div_d;
            par_q       <= par_d;
            stop2_q     <= stop2_d;
            tx_out_q    <= tx_out_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_done = tx_done_q;
    assign ready   = ~fifo_full;
    assign empty   = fifo_empty;
    assign busy    = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_tx_uart_fifo.sv
// Scoreboard bench: stimulus queues hand-built frames, a line monitor decodes and checks them.
module tb_tx_uart_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] div;
    logic [1:0]  data_bits;
    logic [1:0]  parity;
    logic        stop2;
    logic        valid;
    logic [7:0]  tx_data;
    logic        ready;
    logic        tx_out;
    logic        busy;
    logic        empty;
    logic [2:0]  level;
    logic        tx_done;

    tx_uart_fifo #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .div       (div),
        .data_bits (data_bits),
        .parity    (parity),
        .stop2     (stop2),
        .valid     (valid),
        .tx_data   (tx_data),
        .ready     (ready),
        .tx_out    (tx_out),
        .busy      (busy),
        .empty     (empty),
        .level     (level),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [11:0] bits;   // symbol sequence, bit 0 is the start bit
        int          nsym;
        int          dv;     // effective cycles per symbol
        bit          b2b;    // must follow the previous frame with no idle cycle
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input logic [11:0] bits, input int nsym, input int dv,
                                input bit b2b);
        exp_t e;
        e.bits = bits;
        e.nsym = nsym;
        e.dv   = dv;
        e.b2b  = b2b;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Line monitor
    bit          in_frame = 0;
    bit          skip     = 0;
    exp_t        cur;
    int          pos, bad, done_bad, sym;
    int          last_end = -10;
    int          stray    = 0;
    int          frames   = 0;
    logic [11:0] got_bits, m;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame = 0;
                skip     = 0;
            end else begin
                if (skip && tx_out === 1'b1) skip = 0;
                if (!in_frame && !skip) begin
                    if (tx_done !== 1'b0) stray++;
                    if (tx_out === 1'b0) begin
                        check("frame_expected", (sb.size() > 0), 1);
                        if (sb.size() == 0) begin
                            skip = 1;
                        end else begin
                            cur      = sb.pop_front();
                            in_frame = 1;
                            pos      = 0;
                            bad      = 0;
                            done_bad = 0;
                            got_bits = '0;
                            frames++;
                            if (cur.b2b) check("no_idle_gap", cycle - last_end, 1);
                        end
                    end
                end
                if (in_frame) begin
                    sym = pos / cur.dv;
                    if (pos % cur.dv == 0) got_bits[sym] = tx_out;
                    if (tx_out !== cur.bits[sym]) bad++;
                    if (tx_done !== (pos == cur.nsym * cur.dv - 1)) done_bad++;
                    pos++;
                    if (pos == cur.nsym * cur.dv) begin
                        m = (12'h1 << cur.nsym) - 12'h1;
                        n_checks++;
                        if (bad != 0 || (got_bits & m) !== (cur.bits & m)) begin
                            n_fail++;
                            $display("FAIL frame%0d_bits: got %b expected %b (%0d bad cycles)",
                                     frames, got_bits & m, cur.bits & m, bad);
                        end
                        check("frame_done_pulse_errors", done_bad, 0);
                        in_frame = 0;
                        last_end = cycle;
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] d, input exp_t e);
        bit acc;
        acc     = 0;
        valid   = 1'b1;
        tx_data = d;
        for (int k = 0; k < 100 && !acc; k++) begin
            acc = ready;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        check("push_accepted", acc, 1);
        if (acc) sb.push_back(e);
    endtask

    task automatic wait_done(input string name, input int max);
        int k;
        for (k = 0; k < max; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !in_frame && !busy) break;
        end
        check({name, "_drained"}, (k < max), 1);
    endtask

    task automatic wait_frame(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (in_frame) break;
        end
        check({name, "_frame_started"}, (k < 100), 1);
    endtask

    logic [7:0] fill_bytes [6];
    logic [5:0] fill_acc_exp;
    bit         acc;

    initial begin
        reset     = 1'b1;
        valid     = 1'b0;
        tx_data   = 8'h00;
        div       = 16'd4;
        data_bits = 2'd3;
        parity    = 2'd0;
        stop2     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tx_out", tx_out, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_tx_done", tx_done, 0);

        // 8N1 0xA5, div=4, with start-bit latency
        valid   = 1'b1;
        tx_data = 8'hA5;
        @(posedge clk);
        #1;
        valid = 1'b0;
        sb.push_back(mk({1'b1, 8'hA5, 1'b0}, 10, 4, 0));
        check("level_after_push", level, 1);
        check("busy_after_push", busy, 1);
        @(posedge clk);
        #1;
        check("tx_out_e0p1", tx_out, 1);
        @(posedge clk);
        #1;
        check("tx_out_e0p2", tx_out, 0);
        wait_done("8n1", 200);

        // 7E2 0x53: parity 0, two stop symbols
        data_bits = 2'd2;
        parity    = 2'd1;
        stop2     = 1'b1;
        push(8'h53, mk({2'b11, 1'b0, 7'h53, 1'b0}, 11, 4, 0));
        wait_done("7e2", 200);

        // 5O1 0x07: parity 0
        data_bits = 2'd0;
        parity    = 2'd2;
        stop2     = 1'b0;
        push(8'h07, mk({4'b0000, 1'b1, 1'b0, 5'h07, 1'b0}, 8, 4, 0));
        wait_done("5o1", 200);

        // FIFO fill: six back-to-back pushes, sixth rejected
        div          = 16'd2;
        data_bits    = 2'd3;
        parity       = 2'd0;
        fill_bytes   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fill_acc_exp = 6'b011111;
        valid        = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = fill_bytes[i];
            acc     = ready;
            @(posedge clk);
            #1;
            check($sformatf("fill_accept%0d", i), acc, fill_acc_exp[i]);
            if (fill_acc_exp[i]) sb.push_back(mk({1'b1, fill_bytes[i], 1'b0}, 10, 2, i != 0));
            if (i == 4) begin
                check("fill_ready_low", ready, 0);
                check("fill_level4", level, 4);
            end
        end
        valid = 1'b0;
        wait_done("fill", 400);

        // Config change mid-frame: frame 1 stays 8 bits, frame 2 uses 5
        push(8'h3C, mk({1'b1, 8'h3C, 1'b0}, 10, 2, 0));
        push(8'h15, mk({5'b00000, 1'b1, 5'h15, 1'b0}, 7, 2, 1));
        wait_frame("cfg");
        data_bits = 2'd0;
        wait_done("cfg", 200);

        // div=0 and div=1 both give one-cycle symbols
        data_bits = 2'd3;
        div       = 16'd0;
        push(8'h96, mk({1'b1, 8'h96, 1'b0}, 10, 1, 0));
        wait_done("div0", 100);
        div = 16'd1;
        push(8'h5A, mk({1'b1, 8'h5A, 1'b0}, 10, 1, 0));
        wait_done("div1", 100);

        // Reset mid-DATA: frame abandoned, queued bytes dropped
        div = 16'd4;
        push(8'hF0, mk({1'b1, 8'hF0, 1'b0}, 10, 4, 0));
        push(8'h0F, mk({1'b1, 8'h0F, 1'b0}, 10, 4, 1));
        push(8'hAA, mk({1'b1, 8'hAA, 1'b0}, 10, 4, 1));
        check("pre_reset_level", level, 2);
        wait_frame("rst");
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx_out", tx_out, 1);
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        reset = 1'b0;
        sb.delete();
        repeat (200) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("stray_tx_done", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_uart_fifo.md
Name: tx_uart_fifo

Overview:
- Parametrised, FIFO-buffered UART transmitter; next generation of the SoC's single-byte TX UART.
- Adds a configurable frame format: data bits, parity mode and stop-bit count.
- Adds a small TX FIFO with valid/ready push, so software can queue bytes.
- Produces back-to-back frames with no idle gap, plus per-frame done pulses.
- Sits between the SoC MMIO UART register block and the tx pin.

Parameters:
- DATA_W, 8: maximum data bits per frame and width of the FIFO entries; supported range 5..8.
- FIFO_DEPTH, 4: number of FIFO entries; must be a power of two, at least 2.
- DIV_W, 16: width of the baud divisor.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- div  in  DIV_W  clk cycles per symbol (SYSTEM_CYCLES/BAUDRATE).
- data_bits  in  2  frame data bits; 0 => 5, 1 => 6, 2 => 7, 3 => 8.
- parity  in  2  0 = none, 1 = even, 2 = odd, 3 = none.
- stop2  in  1  0 = one stop bit, 1 = two stop bits.
- valid  in  1  push request.
- tx_data  in  DATA_W  byte to send.
- ready  out  1  FIFO not full; a push occurs when valid & ready.
- tx_out  out  1  serial line, idle high.
- busy  out  1  a frame is in progress or the FIFO is not empty.
- empty  out  1  FIFO empty.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- tx_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset state: tx_out=1, ready=1, busy=0, empty=1, level=0, tx_done=0. The FIFO is flushed and the FSM goes to IDLE.
- Reset asserted mid-frame: tx_out=1 after the next edge and the frame is abandoned. No tx_done is issued.
- ready is derived from the registered level only. When full, ready=0 even if a pop happens in the same cycle.
- Push and pop in the same cycle while not full: level is unchanged.
- A push while full is ignored; no data is overwritten.
- div, data_bits, parity and stop2 are sampled into shadow registers when a frame starts. Changes mid-frame take effect from the next frame.
- div==0 is treated as 1. The symbol counter is DIV_W bits wide.
- FSM states:
  - IDLE: tx_out=1. If the FIFO is non-empty, pop the head, latch the config, drive tx_out=0 and go to START.
  - START: hold for div cycles, then go to DATA with bit index 0.
  - DATA: tx_out = data[idx], LSB first, each bit held div cycles. After bit nbits-1, go to PARITY if parity is enabled, else STOP. Data bits at or above nbits are never sent.
  - PARITY: tx_out = XOR of data[nbits-1:0] for even parity, or its inverse for odd. Hold div cycles, then go to STOP.
  - STOP: tx_out=1, held div cycles, or 2*div cycles when stop2 is set.
    - On the final cycle of STOP, pulse tx_done.
    - If the FIFO is non-empty, pop and start the next frame directly, so its start bit follows with no idle cycle.
    - Otherwise go to IDLE.
- Frame length is exactly (1 + nbits + par_en + nstop) * div cycles.
- Latency: a push accepted at edge E0 into an empty FIFO with the FSM idle gives tx_out=0 after edge E0+2.
- busy = (state != IDLE) | !empty.

Decomposition:
- Package tx_uart_pkg holds the FSM state enum (IDLE, START, DATA, PARITY, STOP) and the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
- One sub-module, tx_uart_sync_fifo: a parametrised synchronous FIFO with pointer wrap and level output. The serializer FSM stays in the top level.

Test Plan:
- 8N1 single byte: div=4, push 0xA5 -> tx_out low 2 cycles after accept. Bits 1,0,1,0,0,1,0,1 (LSB first), each 4 cycles, then stop. tx_done pulses at cycle 40 of the frame.
- 7E2 and 5O1 frames: push 0x53 in 7E2 -> parity bit 0, stop held 2*div, frame length 11*div. Push 0x07 in 5O1 -> parity bit 0, frame length 8*div.
- FIFO fill: push 6 bytes back-to-back with FIFO_DEPTH=4 -> ready drops after the 5th accept (4 stored plus 1 popped to the FSM), and level reaches 4. All accepted bytes go out in order, consecutive frames with no idle gap, and the rejected push is not sent.
- Config change mid-frame: switch data_bits from 8 to 5 during frame 1 -> frame 1 stays 8 bits, frame 2 is 5 bits.
- Reset mid-DATA: assert reset for 1 cycle -> tx_out=1 and level=0 on the next edge, no tx_done, and the queued bytes are never sent.
- div=0 and div=1: both give 1-cycle symbols. An 8N1 frame lasts 10 cycles.
